// File: rtl/nf10_decap.sv
// Receive-side tunnel decapsulation on a 256-bit AXI-Stream path: strips the
// 34-byte outer Ethernet/IPv4 header, realigns the payload and fixes the length.
module nf10_decap #(
    parameter int          C_M_AXIS_DATA_WIDTH  = 256,
    parameter int          C_S_AXIS_DATA_WIDTH  = 256,
    parameter int          C_M_AXIS_TUSER_WIDTH = 128,
    parameter int          C_S_AXIS_TUSER_WIDTH = 128,
    parameter int          SRC_PORT_POS         = 16,
    parameter logic [7:0]  DECAP_IP_PROTO       = 8'hFD,
    parameter logic [7:0]  DECAP_SRC_MASK       = 8'h55
) (
    input  logic                                axi_aclk,
    input  logic                                axi_resetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
    input  logic                                s_axis_tvalid,
    output logic                                s_axis_tready,
    input  logic                                s_axis_tlast,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic                                m_axis_tlast,
    output logic [31:0]                         decap_pkt_count,
    output logic [31:0]                         pass_pkt_count
);

    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int SW = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;
    localparam int FW = 1 + UW + SW + DW;

    typedef enum logic [2:0] {
        IDLE,
        SKIP,
        ALIGN,
        FLUSH,
        NORMAL
    } state_t;

    // Four-entry fallthrough input FIFO holding {tlast, tuser, tstrb, tdata}.
    logic [FW-1:0] fifo_mem_q [4];
    logic [FW-1:0] fifo_mem_d [4];
    logic [1:0]    wr_ptr_q, wr_ptr_d;
    logic [1:0]    rd_ptr_q, rd_ptr_d;
    logic [2:0]    fifo_count_q, fifo_count_d;
    logic          fifo_empty;
    logic          fifo_nearly_full;
    logic          fifo_wr;
    logic          fifo_rd;
    logic [FW-1:0] fifo_dout;

    logic [DW-1:0] head_data;
    logic [SW-1:0] head_strb;
    logic [UW-1:0] head_user;
    logic          head_last;
    logic          decap_match;

    state_t        state_q, state_d;
    logic [239:0]  hold_q, hold_d;
    logic [29:0]   hold_strb_q, hold_strb_d;
    logic [UW-1:0] saved_tuser_q, saved_tuser_d;
    logic          first_q, first_d;
    logic [31:0]   decap_pkt_count_q, decap_pkt_count_d;
    logic [31:0]   pass_pkt_count_q, pass_pkt_count_d;
    logic [UW-1:0] adj_tuser;

    assign fifo_empty       = (fifo_count_q == 3'd0);
    assign fifo_nearly_full = (fifo_count_q >= 3'd3);
    assign fifo_wr          = s_axis_tvalid && !fifo_nearly_full;
    assign fifo_dout        = fifo_mem_q[rd_ptr_q];
    assign s_axis_tready    = !fifo_nearly_full;

    assign head_data = fifo_dout[DW-1:0];
    assign head_strb = fifo_dout[DW +: SW];
    assign head_user = fifo_dout[DW+SW +: UW];
    assign head_last = fifo_dout[FW-1];

    assign decap_match = (head_data[103:96] == 8'h08) &&
                         (head_data[111:104] == 8'h00) &&
                         (head_data[191:184] == DECAP_IP_PROTO) &&
                         ((head_user[SRC_PORT_POS +: 8] & DECAP_SRC_MASK) != 8'h00) &&
                         (head_user[15:0] > 16'd34);

    assign adj_tuser = {saved_tuser_q[UW-1:16], saved_tuser_q[15:0] - 16'd34};

    assign decap_pkt_count = decap_pkt_count_q;
    assign pass_pkt_count  = pass_pkt_count_q;

    always_comb begin
        fifo_mem_d   = fifo_mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q;
        if (fifo_wr) begin
            fifo_mem_d[wr_ptr_q] = {s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata};
            wr_ptr_d             = wr_ptr_q + 2'd1;
        end
        if (fifo_rd) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        case ({fifo_wr, fifo_rd})
            2'b10:   fifo_count_d = fifo_count_q + 3'd1;
            2'b01:   fifo_count_d = fifo_count_q - 3'd1;
            default: fifo_count_d = fifo_count_q;
        endcase
    end

    always_comb begin
        state_d           = state_q;
        hold_d            = hold_q;
        hold_strb_d       = hold_strb_q;
        saved_tuser_d     = saved_tuser_q;
        first_d           = first_q;
        decap_pkt_count_d = decap_pkt_count_q;
        pass_pkt_count_d  = pass_pkt_count_q;
        fifo_rd           = 1'b0;
        m_axis_tvalid     = 1'b0;
        m_axis_tdata      = '0;
        m_axis_tstrb      = '0;
        m_axis_tuser      = '0;
        m_axis_tlast      = 1'b0;

        // Outputs stay quiet while reset is held, even before the first edge.
        if (axi_resetn) begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        if (decap_match) begin
                            fifo_rd       = 1'b1;
                            saved_tuser_d = head_user;
                            state_d       = SKIP;
                        end else begin
                            state_d = NORMAL;
                        end
                    end
                end
                SKIP: begin
                    if (!fifo_empty) begin
                        fifo_rd     = 1'b1;
                        hold_d      = head_data[255:16];
                        hold_strb_d = head_strb[31:2];
                        first_d     = 1'b1;
                        state_d     = head_last ? FLUSH : ALIGN;
                    end
                end
                ALIGN: begin
                    if (!fifo_empty) begin
                        m_axis_tvalid = 1'b1;
                        m_axis_tdata  = {head_data[15:0], hold_q};
                        m_axis_tstrb  = {head_strb[1:0], hold_strb_q};
                        m_axis_tuser  = first_q ? adj_tuser : '0;
                        m_axis_tlast  = head_last && !head_strb[2];
                        if (m_axis_tready) begin
                            fifo_rd     = 1'b1;
                            hold_d      = head_data[255:16];
                            hold_strb_d = head_strb[31:2];
                            first_d     = 1'b0;
                            if (head_last) begin
                                if (head_strb[2]) begin
                                    state_d = FLUSH;
                                end else begin
                                    decap_pkt_count_d = decap_pkt_count_q + 32'd1;
                                    state_d           = IDLE;
                                end
                            end
                        end
                    end
                end
                FLUSH: begin
                    m_axis_tvalid = 1'b1;
                    m_axis_tdata  = {16'b0, hold_q};
                    m_axis_tstrb  = {2'b0, hold_strb_q};
                    m_axis_tuser  = first_q ? adj_tuser : '0;
                    m_axis_tlast  = 1'b1;
                    if (m_axis_tready) begin
                        first_d           = 1'b0;
                        decap_pkt_count_d = decap_pkt_count_q + 32'd1;
                        state_d           = IDLE;
                    end
                end
                NORMAL: begin
                    if (!fifo_empty) begin
                        m_axis_tvalid = 1'b1;
                        m_axis_tdata  = head_data;
                        m_axis_tstrb  = head_strb;
                        m_axis_tuser  = head_user;
                        m_axis_tlast  = head_last;
                        if (m_axis_tready) begin
                            fifo_rd = 1'b1;
                            if (head_last) begin
                                pass_pkt_count_d = pass_pkt_count_q + 32'd1;
                                state_d          = IDLE;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge axi_aclk) begin
        fifo_mem_q <= fifo_mem_d;
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_resetn) begin
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            fifo_count_q      <= '0;
            state_q           <= IDLE;
            hold_q            <= '0;
            hold_strb_q       <= '0;
            saved_tuser_q     <= '0;
            first_q           <= 1'b0;
            decap_pkt_count_q <= '0;
            pass_pkt_count_q  <= '0;
        end else begin
            wr_ptr_q          <= wr_ptr_d;
            rd_ptr_q          <= rd_ptr_d;
            fifo_count_q      <= fifo_count_d;
            state_q           <= state_d;
            hold_q            <= hold_d;
            hold_strb_q       <= hold_strb_d;
            saved_tuser_q     <= saved_tuser_d;
            first_q           <= first_d;
            decap_pkt_count_q <= decap_pkt_count_d;
            pass_pkt_count_q  <= pass_pkt_count_d;
        end
    end

endmodule

// File: tb/tb_nf10_decap.sv
// Directed self-checking bench for nf10_decap: pass-through, decap with and
// without a flush beat, source-port masking, output stalls and mid-packet reset.
module tb_nf10_decap;

    logic         axi_aclk = 1'b0;
    logic         axi_resetn;
    logic [255:0] s_axis_tdata;
    logic [31:0]  s_axis_tstrb;
    logic [127:0] s_axis_tuser;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         s_axis_tlast;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tstrb;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;
    logic [31:0]  decap_pkt_count;
    logic [31:0]  pass_pkt_count;

    always #5 axi_aclk = ~axi_aclk;

    nf10_decap dut (
        .axi_aclk        (axi_aclk),
        .axi_resetn      (axi_resetn),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tstrb    (s_axis_tstrb),
        .s_axis_tuser    (s_axis_tuser),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tlast    (s_axis_tlast),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tstrb    (m_axis_tstrb),
        .m_axis_tuser    (m_axis_tuser),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tlast    (m_axis_tlast),
        .decap_pkt_count (decap_pkt_count),
        .pass_pkt_count  (pass_pkt_count)
    );

    int cyc = 0;
    always @(posedge axi_aclk) cyc <= cyc + 1;

    int error_count = 0;
    int check_count = 0;
    int first_acc_cyc;
    int first_out_cyc;

    logic [7:0]   pkt [256];
    int           pkt_len;
    logic [127:0] pkt_user;

    logic [255:0] in_data[$];
    logic [31:0]  in_strb[$];
    logic [127:0] in_user[$];
    logic         in_last[$];
    logic [255:0] exp_data[$];
    logic [31:0]  exp_strb[$];
    logic [127:0] exp_user[$];
    logic         exp_last[$];
    logic [255:0] out_data[$];
    logic [31:0]  out_strb[$];
    logic [127:0] out_user[$];
    logic         out_last[$];
    int           out_cyc[$];

    task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Packet bytes follow a seeded ramp; ethertype and IP protocol are forced.
    task automatic buildPacket(input int len, input logic [7:0] port, input logic [15:0] etype,
                               input logic [7:0] proto, input logic [7:0] seed);
        for (int i = 0; i < 256; i++) pkt[i] = (i < len) ? (8'(i * 3) + seed) : 8'h00;
        pkt[12]  = etype[15:8];
        pkt[13]  = etype[7:0];
        pkt[23]  = proto;
        pkt_len  = len;
        pkt_user = {32'hCAFE0001, 72'h0, port, 16'(len)};
    endtask

    task automatic appendBeats(input int offset, input int nbytes, input logic [127:0] user0, input bit to_exp);
        int nb;
        nb = (nbytes + 31) / 32;
        for (int b = 0; b < nb; b++) begin
            logic [255:0] d;
            logic [31:0]  s;
            logic [127:0] u;
            d = '0;
            s = '0;
            for (int k = 0; k < 32; k++) begin
                if (32 * b + k < nbytes) begin
                    d[8*k +: 8] = pkt[offset + 32 * b + k];
                    s[k]        = 1'b1;
                end
            end
            u = (b == 0) ? user0 : '0;
            if (to_exp) begin
                exp_data.push_back(d); exp_strb.push_back(s);
                exp_user.push_back(u); exp_last.push_back(b == nb - 1);
            end else begin
                in_data.push_back(d); in_strb.push_back(s);
                in_user.push_back(u); in_last.push_back(b == nb - 1);
            end
        end
    endtask

    task automatic queueInput();
        appendBeats(0, pkt_len, pkt_user, 1'b0);
    endtask

    task automatic expectPass();
        appendBeats(0, pkt_len, pkt_user, 1'b1);
    endtask

    task automatic expectDecap();
        appendBeats(34, pkt_len - 34, {pkt_user[127:16], 16'(pkt_len - 34)}, 1'b1);
    endtask

    task automatic applyStimulus(input bit gaps);
        int budget;
        int beat;
        beat          = 0;
        first_acc_cyc = -1;
        @(negedge axi_aclk);
        while (in_data.size() > 0) begin
            s_axis_tdata  = in_data.pop_front();
            s_axis_tstrb  = in_strb.pop_front();
            s_axis_tuser  = in_user.pop_front();
            s_axis_tlast  = in_last.pop_front();
            s_axis_tvalid = 1'b1;
            budget = 0;
            while (!s_axis_tready && budget < 200) begin
                @(negedge axi_aclk);
                budget++;
            end
            if (budget >= 200) begin
                checkOutput("in_ready_timeout", 256'd0, 256'd1);
                break;
            end
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            @(negedge axi_aclk);
            if (gaps && (beat % 2 == 1)) begin
                s_axis_tvalid = 1'b0;
                @(negedge axi_aclk);
            end
            beat++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tstrb  = '0;
        s_axis_tuser  = '0;
    endtask

    task automatic clearQueues();
        in_data.delete();  in_strb.delete();  in_user.delete();  in_last.delete();
        exp_data.delete(); exp_strb.delete(); exp_user.delete(); exp_last.delete();
        out_data.delete(); out_strb.delete(); out_user.delete(); out_last.delete();
        out_cyc.delete();
    endtask

    task automatic compareOutputs(input string name);
        int budget;
        budget = 0;
        while (out_data.size() < exp_data.size() && budget < 500) begin
            @(posedge axi_aclk);
            budget++;
        end
        repeat (4) @(posedge axi_aclk);
        first_out_cyc = (out_cyc.size() > 0) ? out_cyc[0] : -1;
        checkOutput({name, "_beats"}, 256'(out_data.size()), 256'(exp_data.size()));
        for (int i = 0; i < exp_data.size() && i < out_data.size(); i++) begin
            checkOutput($sformatf("%s_b%0d_data", name, i), out_data[i], exp_data[i]);
            checkOutput($sformatf("%s_b%0d_strb", name, i), 256'(out_strb[i]), 256'(exp_strb[i]));
            checkOutput($sformatf("%s_b%0d_user", name, i), 256'(out_user[i]), 256'(exp_user[i]));
            checkOutput($sformatf("%s_b%0d_last", name, i), 256'(out_last[i]), 256'(exp_last[i]));
        end
    endtask

    // Output monitor: records handshakes and checks that a stalled beat holds still.
    logic         stall_pend = 1'b0;
    logic [255:0] st_data;
    logic [31:0]  st_strb;
    logic [127:0] st_user;
    logic         st_last;
    initial begin
        forever begin
            @(negedge axi_aclk);
            #2;
            if (stall_pend) begin
                checkOutput("stall_valid", 256'(m_axis_tvalid), 256'd1);
                checkOutput("stall_data", m_axis_tdata, st_data);
                checkOutput("stall_strb", 256'(m_axis_tstrb), 256'(st_strb));
                checkOutput("stall_user", 256'(m_axis_tuser), 256'(st_user));
                checkOutput("stall_last", 256'(m_axis_tlast), 256'(st_last));
            end
            stall_pend = m_axis_tvalid && !m_axis_tready;
            st_data    = m_axis_tdata;
            st_strb    = m_axis_tstrb;
            st_user    = m_axis_tuser;
            st_last    = m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready) begin
                out_data.push_back(m_axis_tdata);
                out_strb.push_back(m_axis_tstrb);
                out_user.push_back(m_axis_tuser);
                out_last.push_back(m_axis_tlast);
                out_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0] u;
        int           budget;
        axi_resetn    = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tstrb  = '0;
        s_axis_tuser  = '0;
        m_axis_tready = 1'b1;
        clearQueues();

        repeat (3) @(negedge axi_aclk);
        #2;
        checkOutput("rst_tvalid", 256'(m_axis_tvalid), 256'd0);
        checkOutput("rst_tlast", 256'(m_axis_tlast), 256'd0);
        checkOutput("rst_tdata", m_axis_tdata, 256'd0);
        checkOutput("rst_decap_cnt", 256'(decap_pkt_count), 256'd0);
        checkOutput("rst_pass_cnt", 256'(pass_pkt_count), 256'd0);
        checkOutput("rst_s_tready", 256'(s_axis_tready), 256'd1);
        @(negedge axi_aclk);
        axi_resetn = 1'b1;

        $display("[TB] pass-through, ethertype 86DD, 64 bytes");
        buildPacket(64, 8'h01, 16'h86DD, 8'hFD, 8'h10);
        queueInput(); expectPass();
        applyStimulus(1'b0);
        compareOutputs("passA");
        checkOutput("passA_latency", 256'(first_out_cyc - first_acc_cyc), 256'd2);
        checkOutput("passA_pass_cnt", 256'(pass_pkt_count), 256'd1);
        checkOutput("passA_decap_cnt", 256'(decap_pkt_count), 256'd0);
        clearQueues();

        $display("[TB] decap, length 98");
        buildPacket(98, 8'h01, 16'h0800, 8'hFD, 8'h20);
        queueInput(); expectDecap();
        applyStimulus(1'b0);
        compareOutputs("decB");
        checkOutput("decB_latency", 256'(first_out_cyc - first_acc_cyc), 256'd3);
        checkOutput("decB_strb0", 256'(out_strb[0]), 256'hFFFFFFFF);
        checkOutput("decB_strb1", 256'(out_strb[1]), 256'hFFFFFFFF);
        checkOutput("decB_last1", 256'(out_last[1]), 256'd1);
        u = out_user[0];
        checkOutput("decB_len", 256'(u[15:0]), 256'd64);
        checkOutput("decB_byte34", 256'(out_data[0][7:0]), 256'(pkt[34]));
        checkOutput("decB_decap_cnt", 256'(decap_pkt_count), 256'd1);
        clearQueues();

        $display("[TB] decap, length 70 with flush beat");
        buildPacket(70, 8'h04, 16'h0800, 8'hFD, 8'h30);
        queueInput(); expectDecap();
        applyStimulus(1'b0);
        compareOutputs("decC");
        checkOutput("decC_strb1", 256'(out_strb[1]), 256'h0000000F);
        checkOutput("decC_last0", 256'(out_last[0]), 256'd0);
        checkOutput("decC_last1", 256'(out_last[1]), 256'd1);
        u = out_user[0];
        checkOutput("decC_len", 256'(u[15:0]), 256'd36);
        checkOutput("decC_decap_cnt", 256'(decap_pkt_count), 256'd2);
        clearQueues();

        $display("[TB] decap, length 35, then same frame on a masked port");
        buildPacket(35, 8'h10, 16'h0800, 8'hFD, 8'h40);
        queueInput(); expectDecap();
        applyStimulus(1'b0);
        compareOutputs("decD");
        checkOutput("decD_strb0", 256'(out_strb[0]), 256'h1);
        checkOutput("decD_last0", 256'(out_last[0]), 256'd1);
        u = out_user[0];
        checkOutput("decD_len", 256'(u[15:0]), 256'd1);
        clearQueues();
        buildPacket(35, 8'h02, 16'h0800, 8'hFD, 8'h40);
        queueInput(); expectPass();
        applyStimulus(1'b0);
        compareOutputs("passD");
        checkOutput("passD_pass_cnt", 256'(pass_pkt_count), 256'd2);
        checkOutput("passD_decap_cnt", 256'(decap_pkt_count), 256'd3);
        clearQueues();

        $display("[TB] mixed packets with output stalls and input gaps");
        buildPacket(98, 8'h01, 16'h0800, 8'hFD, 8'h50);
        queueInput(); expectDecap();
        buildPacket(64, 8'h01, 16'h0800, 8'h11, 8'h60);
        queueInput(); expectPass();
        buildPacket(70, 8'h40, 16'h0800, 8'hFD, 8'h70);
        queueInput(); expectDecap();
        fork
            applyStimulus(1'b1);
            begin
                for (int i = 0; i < 60; i++) begin
                    @(negedge axi_aclk);
                    m_axis_tready = ((i % 3) != 1);
                end
                m_axis_tready = 1'b1;
            end
        join
        compareOutputs("mixE");
        checkOutput("mixE_decap_cnt", 256'(decap_pkt_count), 256'd5);
        checkOutput("mixE_pass_cnt", 256'(pass_pkt_count), 256'd3);
        clearQueues();

        $display("[TB] reset in the middle of a decap packet");
        buildPacket(200, 8'h01, 16'h0800, 8'hFD, 8'h80);
        queueInput();
        for (int i = 0; i < 3; i++) begin
            in_data.delete(in_data.size() - 1);
            in_strb.delete(in_strb.size() - 1);
            in_user.delete(in_user.size() - 1);
            in_last.delete(in_last.size() - 1);
        end
        applyStimulus(1'b0);
        budget = 0;
        while (out_data.size() < 2 && budget < 100) begin
            @(posedge axi_aclk);
            budget++;
        end
        checkOutput("rstF_align_beats", 256'(out_data.size()), 256'd2);
        @(negedge axi_aclk);
        axi_resetn = 1'b0;
        @(negedge axi_aclk);
        axi_resetn = 1'b1;
        #2;
        checkOutput("rstF_tvalid", 256'(m_axis_tvalid), 256'd0);
        checkOutput("rstF_decap_cnt", 256'(decap_pkt_count), 256'd0);
        checkOutput("rstF_pass_cnt", 256'(pass_pkt_count), 256'd0);
        clearQueues();
        buildPacket(98, 8'h01, 16'h0800, 8'hFD, 8'h90);
        queueInput(); expectDecap();
        applyStimulus(1'b0);
        compareOutputs("rstF_next");
        checkOutput("rstF_next_latency", 256'(first_out_cyc - first_acc_cyc), 256'd3);
        checkOutput("rstF_next_decap_cnt", 256'(decap_pkt_count), 256'd1);
        checkOutput("rstF_next_pass_cnt", 256'(pass_pkt_count), 256'd0);
        clearQueues();

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
